// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiply (IDLE -> FIN directly).
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   operand;
    logic [2*WIDTH-1:0] acc;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;

    logic               accept;
    logic               signed_op;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   div_rem;

    assign accept    = (state == IDLE) && start && !cancel;
    assign busy      = accept || (state != IDLE);
    assign signed_op = !op[0];
    assign abs_a     = (signed_op && src_a[WIDTH-1]) ? -src_a : src_a;
    assign abs_b     = (signed_op && src_b[WIDTH-1]) ? -src_b : src_b;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, operand};
    assign div_rem   = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            count   <= '0;
            operand <= '0;
            acc     <= '0;
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        operand <= abs_b;
                        is_div  <= op[1];
                        neg_q   <= signed_op && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        neg_r   <= signed_op && src_a[WIDTH-1];
                        count   <= '0;
`ifdef MULDIV_FAST_MUL_EN
                        if (!op[1]) begin
                            acc   <= {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
                            state <= FIN;
                        end else begin
                            acc   <= {{WIDTH{1'b0}}, abs_a};
                            state <= RUN;
                        end
`else
                        acc   <= {{WIDTH{1'b0}}, abs_a};
                        state <= RUN;
`endif
                    end else if (!start) begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                RUN: begin
                    if (cancel) begin
                        state <= IDLE;
                    end else begin
                        acc <= is_div ? {div_rem, acc[WIDTH-2:0], !div_diff[WIDTH]}
                                      : {mul_sum, acc[WIDTH-1:1]};
                        if (count == LAST) state <= FIN;
                        else count <= count + 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    if (!cancel) begin
                        done <= 1'b1;
                        if (is_div) begin
                            lo <= neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                            hi <= neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                        end else begin
                            {hi, lo} <= neg_q ? -acc : acc;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized self-checking bench for muldiv_seq against an arithmetic reference model.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int testsRun = 0;
    int testsFailed = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_CYCLES = 2;
`else
    localparam int MUL_CYCLES = 34;
`endif
    localparam int DIV_CYCLES = 34;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .cancel(cancel),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Result as {HI, LO} straight from the MIPS arithmetic rules.
    function automatic logic [63:0] refModel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        int q;
        int r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: return 64'(sa * sb);
            2'b01: return {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0)
                    return {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return {32'd0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {32'(r), 32'(q)};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Issues one operation at the current negedge and follows it to its done cycle.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic withLoWe);
        logic [63:0] exp;
        int cycles;
        int doneEarly;
        exp = refModel(o, a, b);
        start = 1'b1; op = o; src_a = a; src_b = b;
        if (withLoWe) begin
            lo_we = 1'b1;
            wdata = 32'hAA;
        end
        #1 checkOutput("busy_on_start", 64'(busy), 64'd1);
        @(negedge clk);
        start = 1'b0;
        lo_we = 1'b0;
        checkOutput("done_clear", 64'(done), 64'd0);
        cycles = 1;
        doneEarly = 0;
        while (busy && cycles < 100) begin
            cycles++;
            if (done) doneEarly++;
            @(negedge clk);
        end
        checkOutput("busy_cycles", 64'(cycles), 64'(o[1] ? DIV_CYCLES : MUL_CYCLES));
        checkOutput("done_early", 64'(doneEarly), 64'd0);
        checkOutput("done_pulse", 64'(done), 64'd1);
        checkOutput("hi", 64'(hi), 64'(exp[63:32]));
        checkOutput("lo", 64'(lo), 64'(exp[31:0]));
    endtask

    // Preloads HI/LO, starts a DIV and cancels it in the given cycle (RUN or FIN).
    task automatic cancelTest(input int cancelCycle);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h55;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        checkOutput("mt_hi_55", 64'(hi), 64'h55);
        checkOutput("mt_lo_55", 64'(lo), 64'h55);
        start = 1'b1; op = 2'b10; src_a = 32'd1000; src_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < cancelCycle; c++) begin
            hi_we = (c == 5);
            wdata = 32'hAA;
            if (c == 6) checkOutput("hi_we_in_run", 64'(hi), 64'h55);
            @(negedge clk);
        end
        hi_we = 1'b0;
        checkOutput("busy_before_cancel", 64'(busy), 64'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        checkOutput("cancel_busy", 64'(busy), 64'd0);
        checkOutput("cancel_done", 64'(done), 64'd0);
        checkOutput("cancel_hi", 64'(hi), 64'h55);
        checkOutput("cancel_lo", 64'(lo), 64'h55);
        @(negedge clk);
        checkOutput("cancel_done_late", 64'(done), 64'd0);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        resetn = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_hi", 64'(hi), 64'd0);
        checkOutput("reset_lo", 64'(lo), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        applyStimulus(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0);
        applyStimulus(2'b11, 32'd100, 32'd7, 1'b0);
        applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        applyStimulus(2'b11, 32'h1234, 32'd0, 1'b0);
        applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        applyStimulus(2'b10, 32'hFFFF_FF00, 32'd0, 1'b0);
        @(negedge clk);

        cancelTest(10);
        cancelTest(33);

        start = 1'b1; cancel = 1'b1; op = 2'b01; src_a = 32'd5; src_b = 32'd5;
        #1 checkOutput("start_cancel_busy", 64'(busy), 64'd0);
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        checkOutput("start_cancel_idle", 64'(busy), 64'd0);
        @(negedge clk);
        checkOutput("start_cancel_done", 64'(done), 64'd0);
        checkOutput("start_cancel_lo", 64'(lo), 64'h55);

        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hAA;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        checkOutput("mt_hi_aa", 64'(hi), 64'hAA);
        checkOutput("mt_lo_aa", 64'(lo), 64'hAA);

        start = 1'b1; op = 2'b11; src_a = 32'hFFFF; src_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        resetn = 1'b0;
        #1;
        checkOutput("midrun_reset_hi", 64'(hi), 64'd0);
        checkOutput("midrun_reset_lo", 64'(lo), 64'd0);
        checkOutput("midrun_reset_busy", 64'(busy), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_done", 64'(done), 64'd0);
        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        applyStimulus(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b1);

        for (int i = 0; i < 16; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            applyStimulus(rop, ra, rb, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
